bec_cmd_decoder: RTL and testbench
==================================

# bec_cmd_decoder

Receive-side decoder for the `bec` controller's 39-bit command output bus (`y1`..`y39`). Each cycle it samples the bus and turns every non-zero command word into a compact event record: lowest asserted command index, active-bit count, end-of-sequence flag and optional timestamp. Records are buffered in a small FIFO and drained by a downstream consumer through a valid/ready handshake. The block sits between the controller and the trace/checker logic, as the reading end of the controller's command interface.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, at least 2.
- `TS_W`, 16, timestamp width in bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low. Clears all state.
- `cmd_i`  in  39  command word; bit k-1 carries `yk`.
- `cmd_en_i`  in  1  sample qualifier; `cmd_i` is ignored when low.
- `ev_valid_o`  out  1  head FIFO entry is available.
- `ev_ready_i`  in  1  consumer accepts the head entry.
- `ev_op_o`  out  6  lowest asserted index, 1..39.
- `ev_cnt_o`  out  6  popcount of the sampled word, 1..39.
- `ev_end_o`  out  1  sampled word had `y34` (bit 33) set.
- `ev_ts_o`  out  TS_W  capture timestamp. Only present with `BEC_DEC_TIMESTAMP_EN`.
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `ovf_cnt_o`  out  8  dropped-event counter; saturates at 255.
- `seq_cnt_o`  out  8  count of accepted end events; wraps modulo 256.

## Operation
- A sample is taken when `cmd_en_i` is 1 and `|cmd_i` is 1. Zero words produce no event.
- Encoding of each sample:
  - `op` = index of the lowest set bit, plus 1.
  - `cnt` = popcount of the word.
  - `end` = `cmd_i[33]`.
- Push rules:
  - FIFO not full: the record is written.
  - FIFO full with a pop in the same cycle: the record is written and the level stays unchanged.
  - FIFO full with no pop: the record is dropped and `ovf_cnt_o` increments, saturating at 255.
- `seq_cnt_o` increments only when a record with `end`=1 is actually written. Dropped end records do not count.
- Pop occurs when `ev_valid_o` and `ev_ready_i` are both 1.
  - `ev_*` outputs hold stable while `ev_valid_o` is 1 and `ev_ready_i` is 0.
  - Asserting `ev_ready_i` when the FIFO is empty has no effect.
- Read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. Full and empty are decided by comparing the MSBs with the remaining pointer bits.
- Reset, including mid-operation:
  - `ev_valid_o`=0.
  - `level_o`, `ovf_cnt_o`, `seq_cnt_o`, pointers and timestamp all 0.
  - `ev_op_o`, `ev_cnt_o`, `ev_end_o`, `ev_ts_o` all 0.
  - Entries held at reset are discarded.

## Timing
- Push-to-visible latency is 1 cycle. A sample at edge N gives `ev_valid_o`=1 after edge N, so the record can be observed and popped at edge N+1.
- There is no combinational bypass. Outputs are registered or read from storage only.
- Simultaneous push and pop on an empty FIFO cannot happen, because valid is 0 at that point.
- Simultaneous push and pop on a non-empty FIFO leaves the level unchanged.
- The controller changes `y` on the falling edge. Rising-edge sampling therefore sees values that have been stable for half a cycle, and no synchronizer is required.
- Maximum sustained throughput is 1 event per cycle with `ev_ready_i` held high.

## Configuration
- `BEC_DEC_TIMESTAMP_EN` defined:
  - A free-running `TS_W`-bit counter increments every cycle and wraps at 2^TS_W-1 → 0.
  - Its value at the sample edge is stored with each record and presented on `ev_ts_o`.
- `BEC_DEC_TIMESTAMP_EN` undefined:
  - The counter, the stored field and the `ev_ts_o` port are all absent.
  - All other behaviour is identical.

## Structure
- Package `bec_pkg` holds:
  - `CMD_W`=39, `OP_W`=6, `END_BIT`=33.
  - typedef `bec_ev_t` with fields op, cnt, end, and ts under the macro.
  - function `bec_lowest_idx` (39→6) and function `bec_popcnt` (39→6).
- Sub-module `bec_evt_fifo`: a parameterized synchronous FIFO of `bec_ev_t` with push/pop, full/empty and level.
- The top level contains the encoder, the counters, the drop logic and the timestamp counter.

## Test plan
- Reset, then `cmd_i`=39'h0_0000_0001 (bit 0 set) with en=1 for 1 cycle. Required one cycle later: valid=1, op=1, cnt=1, end=0, level=1. Pop → valid=0.
- Bits 34 and 35 set (y35, y36), then bits 2, 27 and 33 set (y3, y28, y34), consumer ready. Required: events op=35/cnt=2/end=0, then op=3/cnt=3/end=1; `seq_cnt_o`=1.
- en=0 with non-zero `cmd_i`, or en=1 with `cmd_i`=0, for 10 cycles. Required: no events, level=0.
- ready=0 and 10 back-to-back pushes with DEPTH=8. Required: level=8, `ovf_cnt_o`=2. Entries then pop in order; the first 8 payloads are preserved.
- FIFO full, push and pop on the same edge. Required: level stays at 8, `ovf_cnt_o` unchanged, new entry lands at the tail.
- `rst` asserted asynchronously with 5 entries held. Required: immediately valid=0 and level=0; after release, `ovf_cnt_o`=0, `seq_cnt_o`=0, timestamp restarts at 0 (macro on).

Source files
------------

// File: rtl/bec_pkg.sv
// bec_pkg: shared widths, event record and encoder helpers (ts field under BEC_DEC_TIMESTAMP_EN)
package bec_pkg;
  localparam int CMD_W = 39;
  localparam int OP_W = 6;
  localparam int END_BIT = 33;
  localparam int BEC_TS_W = 16;
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [OP_W-1:0] cnt;
    logic eos;
`ifdef BEC_DEC_TIMESTAMP_EN
    logic [BEC_TS_W-1:0] ts;
`endif
  } bec_ev_t;
  function automatic logic [OP_W-1:0] bec_lowest_idx(input logic [CMD_W-1:0] w);
    logic [OP_W-1:0] r;
    r = '0;
    for (int i = CMD_W - 1; i >= 0; i--) if (w[i]) r = OP_W'(i + 1);
    return r;
  endfunction
  function automatic logic [OP_W-1:0] bec_popcnt(input logic [CMD_W-1:0] w);
    logic [OP_W-1:0] r;
    r = '0;
    for (int i = 0; i < CMD_W; i++) r = r + OP_W'(w[i]);
    return r;
  endfunction
endpackage

// File: rtl/bec_cmd_decoder_if.sv
// bec_cmd_decoder_if: command input and event output bundle (ev_ts_o under BEC_DEC_TIMESTAMP_EN)
interface bec_cmd_decoder_if import bec_pkg::*; #(
  parameter int DEPTH = 8
`ifdef BEC_DEC_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
);
  logic [CMD_W-1:0] cmd_i;
  logic cmd_en_i;
  logic ev_valid_o;
  logic ev_ready_i;
  logic [OP_W-1:0] ev_op_o;
  logic [OP_W-1:0] ev_cnt_o;
  logic ev_end_o;
`ifdef BEC_DEC_TIMESTAMP_EN
  logic [TS_W-1:0] ev_ts_o;
`endif
  logic [$clog2(DEPTH):0] level_o;
  logic [7:0] ovf_cnt_o;
  logic [7:0] seq_cnt_o;
  modport slave (
    input cmd_i, cmd_en_i, ev_ready_i,
`ifdef BEC_DEC_TIMESTAMP_EN
    output ev_ts_o,
`endif
    output ev_valid_o, ev_op_o, ev_cnt_o, ev_end_o, level_o, ovf_cnt_o, seq_cnt_o
  );
  modport master (
    output cmd_i, cmd_en_i, ev_ready_i,
`ifdef BEC_DEC_TIMESTAMP_EN
    input ev_ts_o,
`endif
    input ev_valid_o, ev_op_o, ev_cnt_o, ev_end_o, level_o, ovf_cnt_o, seq_cnt_o
  );
endinterface

// File: rtl/bec_evt_fifo.sv
// bec_evt_fifo: synchronous FIFO of event records with wrap-bit pointers
module bec_evt_fifo import bec_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  bec_ev_t din,
  output bec_ev_t dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  bec_ev_t mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign level = wp - rp;
  assign dout = mem[rp[AW-1:0]];
  // pointer advance; reset discards held entries
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + ONE;
      if (rd) rp <= rp + ONE;
    end
  // storage write; a full-with-pop write reuses the slot being read out
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/bec_cmd_decoder.sv
// bec_cmd_decoder: encodes bec command words into buffered events (BEC_DEC_TIMESTAMP_EN adds capture timestamps)
module bec_cmd_decoder import bec_pkg::*; #(
  parameter int DEPTH = 8
`ifdef BEC_DEC_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input logic clk,
  input logic rst,
  bec_cmd_decoder_if.slave bus
);
  logic sample, pop, push, drop, full, empty;
  logic [7:0] ovf, seq;
  bec_ev_t din, dout;
`ifdef BEC_DEC_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
`endif
  assign sample = bus.cmd_en_i && |bus.cmd_i;
  assign pop = !empty && bus.ev_ready_i;
  assign push = sample && (!full || pop);
  assign drop = sample && full && !pop;
  // encode the sampled word into an event record
  always_comb begin
    din = '0;
    din.op = bec_lowest_idx(bus.cmd_i);
    din.cnt = bec_popcnt(bus.cmd_i);
    din.eos = bus.cmd_i[END_BIT];
`ifdef BEC_DEC_TIMESTAMP_EN
    din.ts = BEC_TS_W'(ts);
`endif
  end
  bec_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din(din),
    .dout(dout),
    .full(full),
    .empty(empty),
    .level(bus.level_o)
  );
  // saturating drop count and count of written end records
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ovf <= '0;
      seq <= '0;
    end else begin
      if (drop && ovf != 8'hff) ovf <= ovf + 8'd1;
      if (push && din.eos) seq <= seq + 8'd1;
    end
`ifdef BEC_DEC_TIMESTAMP_EN
  // free-running capture timestamp
  always_ff @(posedge clk or negedge rst)
    if (!rst) ts <= '0;
    else ts <= ts + 1'b1;
  assign bus.ev_ts_o = empty ? '0 : TS_W'(dout.ts);
`endif
  assign bus.ev_valid_o = !empty;
  assign bus.ev_op_o = empty ? '0 : dout.op;
  assign bus.ev_cnt_o = empty ? '0 : dout.cnt;
  assign bus.ev_end_o = !empty && dout.eos;
  assign bus.ovf_cnt_o = ovf;
  assign bus.seq_cnt_o = seq;
endmodule

// File: tb/tb_bec_cmd_decoder.sv
// tb_bec_cmd_decoder: vector table plus overflow, saturation and async reset sequences
module tb_bec_cmd_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
`ifdef BEC_DEC_TIMESTAMP_EN
  bec_cmd_decoder_if #(.DEPTH(8), .TS_W(16)) bus ();
  bec_cmd_decoder #(.DEPTH(8), .TS_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  bec_cmd_decoder_if #(.DEPTH(8)) bus ();
  bec_cmd_decoder #(.DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  typedef struct {
    logic en;
    logic [38:0] cmd;
    logic rdy;
    logic v;
    logic [5:0] op;
    logic [5:0] cnt;
    logic e;
    logic [3:0] lvl;
    logic [7:0] seq;
  } vec_t;
  vec_t vt [11];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic drive(input logic en, input logic [38:0] cmd, input logic rdy);
    bus.cmd_en_i = en;
    bus.cmd_i = cmd;
    bus.ev_ready_i = rdy;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [38:0] oh;
    int exp_op [8];
    vt[0]  = '{1'b1, 39'h00_0000_0001, 1'b0, 1'b1, 6'd1,  6'd1,  1'b0, 4'd1, 8'd0};
    vt[1]  = '{1'b0, 39'h00_0000_0000, 1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 8'd0};
    vt[2]  = '{1'b1, 39'h0C_0000_0000, 1'b0, 1'b1, 6'd35, 6'd2,  1'b0, 4'd1, 8'd0};
    vt[3]  = '{1'b1, 39'h02_0800_0004, 1'b1, 1'b1, 6'd3,  6'd3,  1'b1, 4'd1, 8'd1};
    vt[4]  = '{1'b0, 39'h7F_FFFF_FFFF, 1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 8'd1};
    vt[5]  = '{1'b1, 39'h00_0000_0000, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 8'd1};
    vt[6]  = '{1'b0, 39'h40_0000_0000, 1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 8'd1};
    vt[7]  = '{1'b1, 39'h40_0000_0000, 1'b0, 1'b1, 6'd39, 6'd1,  1'b0, 4'd1, 8'd1};
    vt[8]  = '{1'b1, 39'h7F_FFFF_FFFF, 1'b0, 1'b1, 6'd39, 6'd1,  1'b0, 4'd2, 8'd2};
    vt[9]  = '{1'b0, 39'h00_0000_0000, 1'b1, 1'b1, 6'd1,  6'd39, 1'b1, 4'd1, 8'd2};
    vt[10] = '{1'b0, 39'h00_0000_0000, 1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 4'd0, 8'd2};
    drive(1'b0, '0, 1'b0);
    #12;
    chk("rst_valid", bus.ev_valid_o, 0);
    chk("rst_level", bus.level_o, 0);
    chk("rst_op", bus.ev_op_o, 0);
    rst = 1'b1;
    #2;
    step();
    chk("idle_ovf", bus.ovf_cnt_o, 0);
    chk("idle_seq", bus.seq_cnt_o, 0);
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].en, vt[i].cmd, vt[i].rdy);
      step();
      chk($sformatf("v%0d_valid", i), bus.ev_valid_o, vt[i].v);
      chk($sformatf("v%0d_op", i), bus.ev_op_o, vt[i].op);
      chk($sformatf("v%0d_cnt", i), bus.ev_cnt_o, vt[i].cnt);
      chk($sformatf("v%0d_end", i), bus.ev_end_o, vt[i].e);
      chk($sformatf("v%0d_level", i), bus.level_o, vt[i].lvl);
      chk($sformatf("v%0d_seq", i), bus.seq_cnt_o, vt[i].seq);
    end
    for (int i = 0; i < 10; i++) begin
      drive(i[0], i[0] ? 39'h0 : 39'h12_3456_789A, 1'b1);
      step();
      chk($sformatf("ign%0d_valid", i), bus.ev_valid_o, 0);
      chk($sformatf("ign%0d_level", i), bus.level_o, 0);
    end
    for (int i = 0; i < 10; i++) begin
      oh = 39'h1 << i;
      drive(1'b1, oh, 1'b0);
      step();
    end
    chk("full_level", bus.level_o, 8);
    chk("full_ovf", bus.ovf_cnt_o, 2);
    chk("full_head", bus.ev_op_o, 1);
    drive(1'b0, '0, 1'b0);
    step();
    chk("hold_op", bus.ev_op_o, 1);
    chk("hold_level", bus.level_o, 8);
    drive(1'b1, 39'h1 << 20, 1'b1);
    step();
    chk("pp_level", bus.level_o, 8);
    chk("pp_ovf", bus.ovf_cnt_o, 2);
    exp_op = '{2, 3, 4, 5, 6, 7, 8, 21};
    drive(1'b0, '0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_valid", k), bus.ev_valid_o, 1);
      chk($sformatf("drain%0d_op", k), bus.ev_op_o, exp_op[k]);
      step();
    end
    chk("drain_empty", bus.ev_valid_o, 0);
    chk("drain_seq", bus.seq_cnt_o, 2);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 39'h20, 1'b0);
      step();
    end
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 39'h02_0000_0001, 1'b0);
      step();
    end
    chk("sat_ovf", bus.ovf_cnt_o, 255);
    chk("sat_seq", bus.seq_cnt_o, 2);
    chk("sat_level", bus.level_o, 8);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("held5_level", bus.level_o, 5);
    drive(1'b1, 39'h3, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", bus.ev_valid_o, 0);
    chk("arst_level", bus.level_o, 0);
    chk("arst_op", bus.ev_op_o, 0);
    chk("arst_ovf", bus.ovf_cnt_o, 0);
    #3;
    rst = 1'b1;
    step();
    chk("post_valid", bus.ev_valid_o, 1);
    chk("post_op", bus.ev_op_o, 1);
    chk("post_cnt", bus.ev_cnt_o, 2);
    chk("post_level", bus.level_o, 1);
    chk("post_ovf", bus.ovf_cnt_o, 0);
    chk("post_seq", bus.seq_cnt_o, 0);
`ifdef BEC_DEC_TIMESTAMP_EN
    chk("post_ts0", bus.ev_ts_o, 0);
`endif
    drive(1'b1, 39'h40_0000_0000, 1'b0);
    step();
    drive(1'b0, '0, 1'b1);
    step();
    chk("ts2_op", bus.ev_op_o, 39);
`ifdef BEC_DEC_TIMESTAMP_EN
    chk("post_ts1", bus.ev_ts_o, 1);
`endif
    step();
    chk("final_empty", bus.ev_valid_o, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
